// File: rtl/pkt_player.sv
// RAM-backed byte-stream packet source: preload bytes, replay them on valid/ready, then hold an
// inter-packet gap before pulsing done. Define PKT_PLAYER_CRC_EN to append the Ethernet FCS.
module pkt_player #(
  parameter int unsigned AW  = 10,
  parameter int unsigned IPG = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [7:0]    odata,
  output logic          ovalid,
  output logic          olast,
  input  logic          oready
);
  localparam logic [AW:0] Cap     = {1'b1, {AW{1'b0}}};
  localparam logic [7:0]  GapLoad = 8'(IPG - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPref,
    StStream,
`ifdef PKT_PLAYER_CRC_EN
    StCrc,
`endif
    StGap
  } state_e;

  state_e      r_state;
  logic [7:0]  r_mem [2**AW];
  logic [7:0]  r_rdata;
  logic        r_rd_v, r_rd_last;
  logic [AW:0] r_n, r_raddr;
  logic [7:0]  r_gap;
  logic [7:0]  r_odata;
  logic        r_ovalid, r_olast, r_busy, r_done;

  logic          w_active, w_start_go, w_acc, w_move, w_re, w_rd_last, w_pay_end, w_finish;
  logic [AW-1:0] w_raddr;
  logic [AW:0]   w_len_clip, w_raddr_nxt;

`ifdef PKT_PLAYER_CRC_EN
  logic [31:0] r_crc;
  logic [2:0]  r_fcs_idx;
  logic        r_plast;
  logic [31:0] w_crc_nxt, w_crc_fin, w_fcs;
  logic [7:0]  w_fcs_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction
`endif

  always_comb begin
    w_active    = (r_state == StPref) || (r_state == StStream);
    w_start_go  = (r_state == StIdle) && start && (len != '0);
    w_acc       = r_ovalid && oready;
    // The read register doubles as the skid entry; it drains into the output stage.
    w_move      = w_active && r_rd_v && (!r_ovalid || oready);
    w_re        = w_start_go || (w_active && (r_raddr != r_n) && (!r_rd_v || w_move));
    w_raddr     = w_start_go ? '0 : r_raddr[AW-1:0];
    w_len_clip  = (len > Cap) ? Cap : len;
    w_raddr_nxt = w_start_go ? {{AW{1'b0}}, 1'b1} : r_raddr + 1'b1;
    w_rd_last   = (w_raddr_nxt == (w_start_go ? w_len_clip : r_n));
`ifdef PKT_PLAYER_CRC_EN
    w_crc_nxt  = crc_byte(r_crc, r_odata);
    w_crc_fin  = ~w_crc_nxt;
    w_fcs      = ~r_crc;
    w_fcs_byte = w_fcs[{r_fcs_idx[1:0], 3'b000} +: 8];
    w_pay_end  = (r_state == StStream) && w_acc && r_plast;
    w_finish   = ((r_state == StIdle) && start && (len == '0)) ||
                 ((r_state == StCrc) && w_acc && (r_fcs_idx == 3'd4));
`else
    w_pay_end  = (r_state == StStream) && w_acc && r_olast;
    w_finish   = ((r_state == StIdle) && start && (len == '0)) || w_pay_end;
`endif
  end

  always_ff @(posedge clk) begin
    if (ld_we && (r_state == StIdle)) r_mem[ld_addr] <= ld_data;
    if (w_re) r_rdata <= r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_rd_v    <= 1'b0;
      r_rd_last <= 1'b0;
      r_n       <= '0;
      r_raddr   <= '0;
      r_gap     <= '0;
      r_odata   <= '0;
      r_ovalid  <= 1'b0;
      r_olast   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef PKT_PLAYER_CRC_EN
      r_crc     <= '0;
      r_fcs_idx <= '0;
      r_plast   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_re) begin
        r_rd_v    <= 1'b1;
        r_raddr   <= w_raddr_nxt;
        r_rd_last <= w_rd_last;
      end else if (w_move) begin
        r_rd_v <= 1'b0;
      end
      if (w_move) begin
        r_odata  <= r_rdata;
        r_ovalid <= 1'b1;
`ifdef PKT_PLAYER_CRC_EN
        r_plast  <= r_rd_last;
        r_olast  <= 1'b0;
`else
        r_olast  <= r_rd_last;
`endif
      end else if (w_acc) begin
        r_ovalid <= 1'b0;
        r_olast  <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (w_start_go) begin
            r_n     <= w_len_clip;
            r_busy  <= 1'b1;
            r_state <= StPref;
`ifdef PKT_PLAYER_CRC_EN
            r_crc   <= 32'hFFFF_FFFF;
`endif
          end
        end
        StPref: r_state <= StStream;
        StStream: begin
`ifdef PKT_PLAYER_CRC_EN
          if (w_acc) r_crc <= w_crc_nxt;
          if (w_pay_end) begin
            r_odata   <= w_crc_fin[7:0];
            r_ovalid  <= 1'b1;
            r_olast   <= 1'b0;
            r_plast   <= 1'b0;
            r_fcs_idx <= 3'd1;
            r_state   <= StCrc;
          end
`endif
        end
`ifdef PKT_PLAYER_CRC_EN
        StCrc: begin
          if (w_acc && (r_fcs_idx != 3'd4)) begin
            r_odata   <= w_fcs_byte;
            r_ovalid  <= 1'b1;
            r_olast   <= (r_fcs_idx == 3'd3);
            r_fcs_idx <= r_fcs_idx + 3'd1;
          end
        end
`endif
        StGap: begin
          if (r_gap == 8'd1) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
      // Gap counts remaining edges so done lands exactly IPG cycles after the last byte.
      if (w_finish) begin
        if (IPG == 1) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end else begin
          r_gap   <= GapLoad;
          r_busy  <= 1'b1;
          r_state <= StGap;
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign odata  = r_odata;
  assign ovalid = r_ovalid;
  assign olast  = r_olast;

endmodule

// File: tb/tb_pkt_player.sv
// Self-checking bench for pkt_player: a shadow RAM plus expected-byte queue per packet
// (with FCS appended when PKT_PLAYER_CRC_EN is defined) judges every accepted byte and timing.
module tb_pkt_player;
  localparam int unsigned AW  = 6;
  localparam int unsigned IPG = 12;
  localparam int          Cap = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, ld_we, start, oready;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic [AW:0]   len;
  logic          busy, done, ovalid, olast;
  logic [7:0]    odata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          edge_cnt = 0;
  logic [7:0]  m_mem [Cap];
  logic [7:0]  obs_q [$];

  pkt_player #(.AW(AW), .IPG(IPG)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .odata   (odata),
    .ovalid  (ovalid),
    .olast   (olast),
    .oready  (oready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input bit rnd);
    for (int i = 0; i < Cap; i++) begin
      m_mem[i] = rnd ? 8'($urandom) : 8'(i);
      ld_we = 1'b1; ld_addr = AW'(i); ld_data = m_mem[i];
      tick();
    end
    ld_we = 1'b0;
  endtask

  task automatic play(input int plen, input bit rnd, input bit poke);
    logic [7:0] exp_q [$];
    int   n, got, start_edge, first_edge, last_acc_edge, done_edge, stall_err, drop_err, extra;
    logic pv, pr, pl;
    logic [7:0] pd;
`ifdef PKT_PLAYER_CRC_EN
    logic [31:0] c;
`endif
    n = (plen > Cap) ? Cap : plen;
    for (int i = 0; i < n; i++) exp_q.push_back(m_mem[i]);
`ifdef PKT_PLAYER_CRC_EN
    if (n > 0) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
        c = c ^ {24'h0, exp_q[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    end
`endif
    obs_q.delete();
    start = 1'b1; len = (AW+1)'(plen); oready = 1'b1;
    tick();
    start = 1'b0; start_edge = edge_cnt;
    check("busy_on_start", 32'(busy), 1);
    check("no_valid_on_start", 32'(ovalid), 0);
    got = 0; first_edge = -1; done_edge = -1; last_acc_edge = 0;
    stall_err = 0; drop_err = 0; extra = 0;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = 8'h0;
    for (int cyc = 0; cyc < 400 && done_edge < 0; cyc++) begin
      if (pv && !pr && (ovalid !== 1'b1 || odata !== pd || olast !== pl)) stall_err++;
      if (!ovalid && got > 0 && got < exp_q.size()) drop_err++;
      if (ovalid && first_edge < 0) first_edge = edge_cnt;
      if (done) begin
        done_edge = edge_cnt;
      end else begin
        oready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (poke && got == 3) begin
          start = 1'b1; len = 5; ld_we = 1'b1; ld_addr = 3; ld_data = ~m_mem[3];
        end else begin
          start = 1'b0; ld_we = 1'b0;
        end
        if (ovalid && oready) begin
          if (got < exp_q.size()) begin
            check("byte_data", 32'(odata), 32'(exp_q[got]));
            check("byte_last", 32'(olast), 32'(got == exp_q.size() - 1));
          end else begin
            extra++;
          end
          obs_q.push_back(odata);
          got++;
          last_acc_edge = edge_cnt + 1;
        end
        pv = ovalid; pr = oready; pd = odata; pl = olast;
        tick();
      end
    end
    start = 1'b0; ld_we = 1'b0;
    check("done_seen", 32'(done_edge >= 0), 1);
    check("byte_count", got, exp_q.size());
    check("no_extra_bytes", extra, 0);
    check("stall_stable", stall_err, 0);
    check("no_valid_drop", drop_err, 0);
    if (exp_q.size() > 0) begin
      check("done_latency", done_edge - last_acc_edge, IPG - 1);
      if (!rnd) check("first_byte_latency", first_edge - start_edge, 1);
    end else begin
      check("len0_latency", done_edge - start_edge, IPG - 1);
      check("len0_no_valid", first_edge, -1);
    end
    check("busy_at_done", 32'(busy), 0);
    tick();
    check("done_pulse", 32'(done), 0);
  endtask

  initial begin
    int spur;
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; len = '0; oready = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovalid", 32'(ovalid), 0);
    check("rst_olast", 32'(olast), 0);
    check("rst_odata", 32'(odata), 0);
    rst = 1'b0;
    tick();

    load(1'b0);
    play(64, 1'b0, 1'b0);
    play(64, 1'b1, 1'b0);
    play(0, 1'b0, 1'b0);
    play(40, 1'b1, 1'b1);
    play(64, 1'b0, 1'b0);
    play(Cap + 5, 1'b0, 1'b0);
    play(2 * Cap - 1, 1'b1, 1'b0);
    play(1, 1'b1, 1'b0);

    load(1'b1);
    for (int i = 0; i < 4; i++) play(int'($urandom_range(1, 2 * Cap - 1)), 1'b1, 1'b0);

    start = 1'b1; len = 64; oready = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("pre_rst_byte10", {23'h0, ovalid, odata}, {23'h0, 1'b1, m_mem[10]});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ovalid", 32'(ovalid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_odata", 32'(odata), 0);
    spur = 0;
    repeat (IPG + 4) begin
      if (done || ovalid || busy) spur++;
      tick();
    end
    check("no_activity_after_rst", spur, 0);
    play(64, 1'b0, 1'b0);

`ifdef PKT_PLAYER_CRC_EN
    for (int i = 0; i < 9; i++) begin
      m_mem[i] = 8'h31 + 8'(i);
      ld_we = 1'b1; ld_addr = AW'(i); ld_data = m_mem[i];
      tick();
    end
    ld_we = 1'b0;
    play(9, 1'b0, 1'b0);
    check("fcs_count", obs_q.size(), 13);
    if (obs_q.size() == 13) begin
      check("fcs_b0", 32'(obs_q[9]), 32'h26);
      check("fcs_b1", 32'(obs_q[10]), 32'h39);
      check("fcs_b2", 32'(obs_q[11]), 32'hF4);
      check("fcs_b3", 32'(obs_q[12]), 32'hCB);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
